// File: rtl/player1_ctrl.sv
// Player 1 movement and death-animation controller. All state advances only on
// the vertical-blanking frame tick, so the sprite renderer never sees mid-frame changes.
module player1_ctrl #(
    parameter int START_X     = 32,
    parameter int START_Y     = 32,
    parameter int MIN_X       = 0,
    parameter int MAX_X       = 768,
    parameter int MIN_Y       = 0,
    parameter int MAX_Y       = 568,
    parameter int SPEED       = 2,
    parameter int ANIM_FRAMES = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               frame_tick,
    input  logic               key_up,
    input  logic               key_down,
    input  logic               key_left,
    input  logic               key_right,
    input  logic               hit,
    input  logic               respawn,
    output logic signed [10:0] centerX1,
    output logic signed [10:0] centerY1,
    output logic [2:0]         sprite_num,
    output logic               alive
);

    localparam int CW = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(ANIM_FRAMES - 1);

    localparam logic signed [11:0] MIN_X_S = 12'(MIN_X);
    localparam logic signed [11:0] MAX_X_S = 12'(MAX_X);
    localparam logic signed [11:0] MIN_Y_S = 12'(MIN_Y);
    localparam logic signed [11:0] MAX_Y_S = 12'(MAX_Y);
    localparam logic signed [11:0] SPEED_S = 12'(SPEED);
    localparam logic signed [10:0] START_X_S = 11'(START_X);
    localparam logic signed [10:0] START_Y_S = 11'(START_Y);

    localparam logic [2:0] SPR_DOWN   = 3'd0;
    localparam logic [2:0] SPR_UP     = 3'd1;
    localparam logic [2:0] SPR_LEFT   = 3'd2;
    localparam logic [2:0] SPR_RIGHT  = 3'd3;
    localparam logic [2:0] SPR_DIE0   = 3'd4;
    localparam logic [2:0] SPR_DIELST = 3'd6;

    typedef enum logic [1:0] {
        ST_ALIVE = 2'd0,
        ST_DYING = 2'd1,
        ST_DEAD  = 2'd2
    } state_t;

    state_t             state_q;
    logic signed [10:0] x_q;
    logic signed [10:0] y_q;
    logic [2:0]         sprite_q;
    logic [CW-1:0]      cnt_q;
    logic               alive_q;

    logic signed [11:0] x_ext, y_ext;
    logic signed [11:0] x_dec, x_inc, y_dec, y_inc;
    logic signed [10:0] x_left_d, x_right_d, y_up_d, y_down_d;

    // Candidates are formed one bit wider than the position so the clamp sees
    // the true overshoot instead of a wrapped value.
    always_comb begin
        x_ext = {x_q[10], x_q};
        y_ext = {y_q[10], y_q};
        x_dec = x_ext - SPEED_S;
        x_inc = x_ext + SPEED_S;
        y_dec = y_ext - SPEED_S;
        y_inc = y_ext + SPEED_S;
        x_left_d  = (x_dec < MIN_X_S) ? MIN_X_S[10:0] : x_dec[10:0];
        x_right_d = (x_inc > MAX_X_S) ? MAX_X_S[10:0] : x_inc[10:0];
        y_up_d    = (y_dec < MIN_Y_S) ? MIN_Y_S[10:0] : y_dec[10:0];
        y_down_d  = (y_inc > MAX_Y_S) ? MAX_Y_S[10:0] : y_inc[10:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_ALIVE;
            x_q      <= START_X_S;
            y_q      <= START_Y_S;
            sprite_q <= SPR_DOWN;
            cnt_q    <= '0;
            alive_q  <= 1'b1;
        end else if (frame_tick) begin
            case (state_q)
                ST_ALIVE: begin
                    if (hit) begin
                        state_q  <= ST_DYING;
                        sprite_q <= SPR_DIE0;
                        cnt_q    <= '0;
                        alive_q  <= 1'b0;
                    end else if (key_up) begin
                        y_q      <= y_up_d;
                        sprite_q <= SPR_UP;
                    end else if (key_down) begin
                        y_q      <= y_down_d;
                        sprite_q <= SPR_DOWN;
                    end else if (key_left) begin
                        x_q      <= x_left_d;
                        sprite_q <= SPR_LEFT;
                    end else if (key_right) begin
                        x_q      <= x_right_d;
                        sprite_q <= SPR_RIGHT;
                    end
                end
                ST_DYING: begin
                    // Each death sprite is held for ANIM_FRAMES ticks; the last one hands over to DEAD.
                    if (cnt_q < CNT_LAST) begin
                        cnt_q <= cnt_q + CW'(1);
                    end else begin
                        cnt_q <= '0;
                        if (sprite_q < SPR_DIELST) begin
                            sprite_q <= sprite_q + 3'd1;
                        end else begin
                            state_q <= ST_DEAD;
                        end
                    end
                end
                ST_DEAD: begin
                    sprite_q <= SPR_DIELST;
                    alive_q  <= 1'b0;
                    if (respawn) begin
                        state_q  <= ST_ALIVE;
                        x_q      <= START_X_S;
                        y_q      <= START_Y_S;
                        sprite_q <= SPR_DOWN;
                        cnt_q    <= '0;
                        alive_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q  <= ST_ALIVE;
                    x_q      <= START_X_S;
                    y_q      <= START_Y_S;
                    sprite_q <= SPR_DOWN;
                    cnt_q    <= '0;
                    alive_q  <= 1'b1;
                end
            endcase
        end
    end

    assign centerX1   = x_q;
    assign centerY1   = y_q;
    assign sprite_num = sprite_q;
    assign alive      = alive_q;

endmodule

// File: tb/tb_player1_ctrl.sv
// Scoreboard bench for player1_ctrl: a behavioural model queues the expected
// outputs for every tick; a monitor pops and compares one clk after the tick.
module tb_player1_ctrl;

    localparam int START_X = 32, START_Y = 32, MIN_X = 0, MAX_X = 768;
    localparam int MIN_Y = 0, MAX_Y = 568, SPEED = 2, ANIM_FRAMES = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic frame_tick = 1'b0;
    logic key_up = 1'b0, key_down = 1'b0, key_left = 1'b0, key_right = 1'b0;
    logic hit = 1'b0, respawn = 1'b0;
    logic signed [10:0] centerX1, centerY1;
    logic [2:0] sprite_num;
    logic alive;

    player1_ctrl dut (
        .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick),
        .key_up(key_up), .key_down(key_down), .key_left(key_left), .key_right(key_right),
        .hit(hit), .respawn(respawn),
        .centerX1(centerX1), .centerY1(centerY1), .sprite_num(sprite_num), .alive(alive)
    );

    always #5 clk = ~clk;

    typedef struct { int x; int y; int sp; int al; } exp_t;
    exp_t sb_q[$];
    exp_t held;

    int checks = 0;
    int failures = 0;
    int tick_run = 0;

    // model state: 0 alive, 1 dying, 2 dead
    int m_x, m_y, m_sp, m_al, m_st, m_cnt;

    task automatic check_val(input string tag, input int got, input int want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, want);
        end else begin
            $display("ok   %s value=%0d", tag, got);
        end
    endtask

    task automatic model_reset();
        m_x = START_X; m_y = START_Y; m_sp = 0; m_al = 1; m_st = 0; m_cnt = 0;
    endtask

    task automatic model_step(input bit u, input bit d, input bit l, input bit r,
                              input bit h, input bit rs);
        if (m_st == 0) begin
            if (h) begin
                m_st = 1; m_sp = 4; m_cnt = 0; m_al = 0;
            end else if (u) begin
                m_y = (m_y - SPEED < MIN_Y) ? MIN_Y : m_y - SPEED; m_sp = 1;
            end else if (d) begin
                m_y = (m_y + SPEED > MAX_Y) ? MAX_Y : m_y + SPEED; m_sp = 0;
            end else if (l) begin
                m_x = (m_x - SPEED < MIN_X) ? MIN_X : m_x - SPEED; m_sp = 2;
            end else if (r) begin
                m_x = (m_x + SPEED > MAX_X) ? MAX_X : m_x + SPEED; m_sp = 3;
            end
        end else if (m_st == 1) begin
            m_cnt++;
            if (m_cnt == ANIM_FRAMES) begin
                m_cnt = 0;
                if (m_sp == 6) m_st = 2;
                else m_sp++;
            end
        end else begin
            m_sp = 6; m_al = 0;
            if (rs) begin
                m_st = 0; m_x = START_X; m_y = START_Y; m_sp = 0; m_al = 1;
            end
        end
    endtask

    task automatic do_tick(input bit u, input bit d, input bit l, input bit r,
                           input bit h, input bit rs);
        @(negedge clk);
        key_up = u; key_down = d; key_left = l; key_right = r; hit = h; respawn = rs;
        frame_tick = 1'b1;
        model_step(u, d, l, r, h, rs);
        sb_q.push_back('{m_x, m_y, m_sp, m_al});
        @(negedge clk);
        frame_tick = 1'b0;
        key_up = 0; key_down = 0; key_left = 0; key_right = 0; hit = 0; respawn = 0;
    endtask

    task automatic rand_tick();
        do_tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endtask

    task automatic check_outs(input string tag, input int x, input int y, input int sp, input int al);
        check_val({tag, "_x"}, int'(centerX1), x);
        check_val({tag, "_y"}, int'(centerY1), y);
        check_val({tag, "_sprite"}, int'(sprite_num), sp);
        check_val({tag, "_alive"}, int'(alive), al);
    endtask

    // Outputs must match the queued expectation one clk after a tick and hold otherwise.
    always @(posedge clk) begin
        if (reset_n) begin
            if (frame_tick) begin
                tick_run++;
                if (tick_run > 1) $display("protocol violation: frame_tick high for %0d cycles", tick_run);
                #1;
                if (sb_q.size() == 0) begin
                    check_val("sb_underflow", 1, 0);
                end else begin
                    held = sb_q.pop_front();
                    check_outs("tick", held.x, held.y, held.sp, held.al);
                end
            end else begin
                tick_run = 0;
                #1;
                if (reset_n) check_outs("hold", held.x, held.y, held.sp, held.al);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        held = '{START_X, START_Y, 0, 1};
        repeat (3) @(negedge clk);
        check_outs("reset", 32, 32, 0, 1);
        reset_n = 1'b1;

        // Keys and events without a tick must change nothing.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            key_up = 1'($urandom_range(0, 1)); key_down = 1'($urandom_range(0, 1));
            key_left = 1'($urandom_range(0, 1)); key_right = 1'($urandom_range(0, 1));
            hit = 1'($urandom_range(0, 1)); respawn = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        key_up = 0; key_down = 0; key_left = 0; key_right = 0; hit = 0; respawn = 0;
        check_outs("notick", 32, 32, 0, 1);

        for (int i = 0; i < 10; i++) do_tick(0, 0, 0, 1, 0, 0);
        check_outs("right10", 52, 32, 3, 1);

        while (m_x < 766) do_tick(0, 0, 0, 1, 0, 0);
        check_val("pre_clamp_x", int'(centerX1), 766);
        do_tick(0, 0, 0, 1, 0, 0);
        check_val("clamp1_x", int'(centerX1), 768);
        do_tick(0, 0, 0, 1, 0, 0);
        check_outs("clamp2", 768, 32, 3, 1);

        for (int i = 0; i < 17; i++) do_tick(1, 0, 0, 0, 0, 0);
        check_outs("clamp_up", 768, 0, 1, 1);

        for (int i = 0; i < 16; i++) do_tick(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) do_tick(1, 0, 1, 1, 0, 0);
        check_outs("priority", 768, 22, 1, 1);

        for (int i = 0; i < 3; i++) do_tick(0, 0, 1, 1, 0, 1);
        do_tick(0, 0, 0, 0, 0, 0);
        check_outs("left3", 762, 22, 2, 1);

        do_tick(0, 1, 0, 0, 1, 0);
        check_outs("hit", 762, 22, 4, 0);
        for (int i = 1; i <= 7; i++) rand_tick();
        check_val("die7_sprite", int'(sprite_num), 4);
        rand_tick();
        check_val("die8_sprite", int'(sprite_num), 5);
        for (int i = 9; i <= 16; i++) rand_tick();
        check_val("die16_sprite", int'(sprite_num), 6);
        for (int i = 17; i <= 24; i++) rand_tick();
        check_val("dead_state", m_st, 2);
        do_tick(1, 1, 1, 1, 1, 0);
        check_outs("dead", 762, 22, 6, 0);
        do_tick(0, 0, 0, 0, 0, 1);
        check_outs("respawn", 32, 32, 0, 1);

        // Asynchronous reset in the middle of the second death sprite.
        do_tick(0, 0, 0, 1, 1, 0);
        for (int i = 0; i < 8; i++) do_tick(0, 0, 0, 0, 0, 0);
        check_val("pre_areset_sprite", int'(sprite_num), 5);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check_outs("areset", 32, 32, 0, 1);
        model_reset();
        held = '{START_X, START_Y, 0, 1};
        @(negedge clk);
        reset_n = 1'b1;
        do_tick(0, 0, 0, 0, 0, 0);
        check_outs("post_areset", 32, 32, 0, 1);
        do_tick(0, 1, 0, 0, 0, 0);
        check_outs("post_areset_down", 32, 34, 0, 1);

        repeat (2) @(negedge clk);
        check_val("sb_drained", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
